// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: request front-end for the single-port memory block.
//
// Buffers read/write commands from a producer in a small command FIFO and
// issues them one at a time on the memory valid/ready interface. Each
// transaction walks IDLE -> REQ -> GAP, so at most one command completes
// every three cycles. Completed reads return a one-cycle response pulse.
//
// Optional feature: define MEM_REQ_TIMEOUT_EN to abandon a request after
// TIMEOUT_CYCLES posedges in REQ without ready. The command is dropped and
// err pulses for one cycle. Without the macro, REQ waits indefinitely and
// err is tied to 0.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   req_valid/req_ready               producer command handshake
//   req_wr_rd/req_addr/req_wdata      command payload (1 = write)
//   valid/ready                       memory request handshake
//   wr_rd/addr/wdata                  memory request payload (registered)
//   rdata                             memory read data, valid at handshake
//   rsp_valid/rsp_data/rsp_addr       read response pulse and payload
//   cmd_count                         FIFO occupancy
//   err                               timeout pulse
module mem_req_ctrl #(
    parameter int WIDTH          = 8,
    parameter int DEPTH          = 16,
    parameter int ADDR_WIDTH     = $clog2(DEPTH),
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_wr_rd,
    input  logic [ADDR_WIDTH-1:0]          req_addr,
    input  logic [WIDTH-1:0]               req_wdata,
    output logic                           valid,
    input  logic                           ready,
    output logic                           wr_rd,
    output logic [ADDR_WIDTH-1:0]          addr,
    output logic [WIDTH-1:0]               wdata,
    input  logic [WIDTH-1:0]               rdata,
    output logic                           rsp_valid,
    output logic [WIDTH-1:0]               rsp_data,
    output logic [ADDR_WIDTH-1:0]          rsp_addr,
    output logic [$clog2(CMD_DEPTH+1)-1:0] cmd_count,
    output logic                           err
);

    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CNT_W = $clog2(CMD_DEPTH + 1);
    localparam int ENT_W = 1 + ADDR_WIDTH + WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("mem_req_ctrl: CMD_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    logic [ENT_W-1:0]      fifo_mem [CMD_DEPTH];
    logic [ENT_W-1:0]      head;

    logic [1:0]            state_q, state_d;
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  valid_q, valid_d;
    logic                  wr_rd_q, wr_rd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]      rsp_data_q, rsp_data_d;
    logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
    logic                  push, pop;

`ifdef MEM_REQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  err_q, err_d;
`endif

    assign req_ready = (count_q != CNT_W'(CMD_DEPTH));
    assign push      = req_valid && req_ready;
    // Pops only happen from IDLE, and only when something is queued.
    // Since a push needs a free slot, a simultaneous push never targets
    // the entry being popped.
    assign pop       = (state_q == S_IDLE) && (count_q != '0);
    assign head      = fifo_mem[rptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr_q] <= {req_wr_rd, req_addr, req_wdata};
        end
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        wr_rd_d     = wr_rd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_addr_d  = rsp_addr_q;
`ifdef MEM_REQ_TIMEOUT_EN
        tmo_d       = tmo_q;
        err_d       = 1'b0;
`endif

        wptr_d = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    {wr_rd_d, addr_d, wdata_d} = head;
                    valid_d = 1'b1;
                    state_d = S_REQ;
`ifdef MEM_REQ_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            S_REQ: begin
                if (valid_q && ready) begin
                    valid_d = 1'b0;
                    state_d = S_GAP;
                    if (!wr_rd_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = rdata;
                        rsp_addr_d  = addr_q;
                    end
`ifdef MEM_REQ_TIMEOUT_EN
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    // Give up on this command; a dropped read yields no response.
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_GAP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
`endif
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            wr_rd_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_addr_q  <= '0;
`ifdef MEM_REQ_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            wr_rd_q     <= wr_rd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_addr_q  <= rsp_addr_d;
`ifdef MEM_REQ_TIMEOUT_EN
            tmo_q       <= tmo_d;
            err_q       <= err_d;
`endif
        end
    end

    assign valid     = valid_q;
    assign wr_rd     = wr_rd_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_addr  = rsp_addr_q;
    assign cmd_count = count_q;

`ifdef MEM_REQ_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
